mem_port_arbiter: RTL

Arbitrates the single-port unified memory between the MIPS processor's instruction-fetch path and its load/store path. Each requester gets a request/acknowledge handshake; the block serialises accesses onto one memory port with variable-latency ready and raises a stall so the processor freezes PC and register writes until its accesses complete. A wait-state timeout keeps the core from hanging on an unresponsive memory.

---
 rtl/mem_port_arbiter.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Serialises the MIPS core's instruction-fetch and load/store requests onto a
// single unified memory port with variable-latency completion (mem_ready).
// A combinational stall freezes the core while either requester is waiting.
// A wait-state counter aborts an access that never completes, returning
// ERR_DATA and setting a sticky bus error.
//
// Ports
//   clk        : single clock, all state on the rising edge
//   reset      : asynchronous, active-low reset
//   if_req     : fetch request, held with if_addr until if_ack
//   if_addr    : fetch address
//   if_rdata   : fetched word, valid with if_ack, held until the next if_ack
//   if_ack     : one-cycle fetch completion pulse
//   dm_req     : data request, held with dm_we/dm_addr/dm_wdata until dm_ack
//   dm_we      : 1 = store, 0 = load
//   dm_addr    : data address
//   dm_wdata   : store data
//   dm_rdata   : load data (0 on store), valid with dm_ack, held until next dm_ack
//   dm_ack     : one-cycle data completion pulse
//   mem_req    : memory strobe, held until mem_ready or abort
//   mem_we     : memory write enable (0 for fetch)
//   mem_addr   : registered memory address
//   mem_wdata  : registered store data (0 for fetch)
//   mem_rdata  : memory read data, sampled with mem_ready
//   mem_ready  : memory completion, only meaningful while mem_req is high
//   cpu_stall  : high while any request is outstanding and not yet acked
//   bus_err    : sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              cpu_stall,
  output logic              bus_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_IF_BUSY = 2'd1,
    S_DM_BUSY = 2'd2
  } state_e;

  localparam logic        GRANT_IF  = 1'b0;
  localparam logic        GRANT_DM  = 1'b1;
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  state_e              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                last_grant_q, last_grant_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic                if_ack_q, if_ack_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                dm_ack_q, dm_ack_d;
  logic                bus_err_q, bus_err_d;

  logic                if_eff_s, dm_eff_s;
  logic                grant_if_s, grant_dm_s;
  logic                timeout_s;

  // A requester still shows req during its ack cycle, so mask it out there.
  assign if_eff_s  = if_req & ~if_ack_q;
  assign dm_eff_s  = dm_req & ~dm_ack_q;

  // mem_ready wins when it coincides with the final wait cycle.
  assign timeout_s = (cnt_q == TIMEOUT_C) & ~mem_ready;

  // Round-robin grant decision for the IDLE state.
  always_comb begin
    grant_if_s = 1'b0;
    grant_dm_s = 1'b0;
    if (if_eff_s && dm_eff_s) begin
      if (last_grant_q == GRANT_DM) begin
        grant_if_s = 1'b1;
      end else begin
        grant_dm_s = 1'b1;
      end
    end else begin
      grant_if_s = if_eff_s;
      grant_dm_s = dm_eff_s;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (grant_if_s) begin
          state_d = S_IF_BUSY;
        end else if (grant_dm_s) begin
          state_d = S_DM_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_IF_BUSY, S_DM_BUSY: begin
        if (mem_ready || timeout_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values; everything not touched holds its value.
  always_comb begin
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    if_ack_d     = 1'b0;
    dm_rdata_d   = dm_rdata_q;
    dm_ack_d     = 1'b0;
    bus_err_d    = bus_err_q;
    case (state_q)
      S_IDLE: begin
        if (grant_if_s) begin
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr;
          mem_wdata_d  = {DATA_W{1'b0}};
          cnt_d        = 16'd0;
          last_grant_d = GRANT_IF;
        end else if (grant_dm_s) begin
          mem_req_d    = 1'b1;
          mem_we_d     = dm_we;
          mem_addr_d   = dm_addr;
          mem_wdata_d  = dm_wdata;
          cnt_d        = 16'd0;
          last_grant_d = GRANT_DM;
        end else begin
          mem_req_d    = 1'b0;
        end
      end
      S_IF_BUSY: begin
        if (mem_ready) begin
          mem_req_d  = 1'b0;
          if_rdata_d = mem_rdata;
          if_ack_d   = 1'b1;
        end else if (timeout_s) begin
          mem_req_d  = 1'b0;
          if_rdata_d = ERR_DATA;
          if_ack_d   = 1'b1;
          bus_err_d  = 1'b1;
        end else begin
          cnt_d      = cnt_q + 16'd1;
        end
      end
      S_DM_BUSY: begin
        if (mem_ready) begin
          mem_req_d  = 1'b0;
          // Stores acknowledge with zero rather than whatever the bus returns.
          dm_rdata_d = mem_we_q ? {DATA_W{1'b0}} : mem_rdata;
          dm_ack_d   = 1'b1;
        end else if (timeout_s) begin
          mem_req_d  = 1'b0;
          dm_rdata_d = ERR_DATA;
          dm_ack_d   = 1'b1;
          bus_err_d  = 1'b1;
        end else begin
          cnt_d      = cnt_q + 16'd1;
        end
      end
      default: begin
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q        <= 16'd0;
      last_grant_q <= GRANT_DM;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_wdata_q  <= {DATA_W{1'b0}};
      if_rdata_q   <= {DATA_W{1'b0}};
      if_ack_q     <= 1'b0;
      dm_rdata_q   <= {DATA_W{1'b0}};
      dm_ack_q     <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      if_ack_q     <= if_ack_d;
      dm_rdata_q   <= dm_rdata_d;
      dm_ack_q     <= dm_ack_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_ack    = if_ack_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_ack    = dm_ack_q;
  assign bus_err   = bus_err_q;
  assign cpu_stall = (if_req & ~if_ack_q) | (dm_req & ~dm_ack_q);

endmodule
